// File: rtl/gray_arb_pkg.sv
// Shared definitions for the gray-image read-port arbiter.
// Build option: define GRAY_ARB_STAT_EN to add per-engine beat counters (stat_o).
package gray_arb_pkg;

    localparam int IMG_W     = 128;
    localparam int IMG_PIX   = 16384;
    localparam int AW_DEF    = 14;
    localparam int DW_DEF    = 8;
    localparam int BURST_MAX = 15;
    localparam int CNT_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/gray_rd_arb_rr_pick.sv
// Cyclic first-one picker: finds the first unmasked requester at or after start.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [N-1:0]   avail;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             pos;

    // Rotate the request vector so start sits at bit 0, then take the lowest set bit.
    always_comb begin
        avail = req & ~mask;
        dbl   = {avail, avail};
        rot   = N'(dbl >> start);
        found = 1'b0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end
        pos = pos + int'(start);
        if (pos >= N) begin
            pos = pos - N;
        end
        idx = PW'(pos);
    end

endmodule

// File: rtl/gray_rd_arb.sv
// Round-robin arbiter sharing one gray-image read port between NREQ LBP engines.
// Grants are held for up to BURST beats so 3x3 window fetches stay contiguous;
// read data is returned to the owning engine one cycle after each beat.
// Build option: define GRAY_ARB_STAT_EN to add stat_o, per-engine saturating beat counters.
module gray_rd_arb
    import gray_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int BURST = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gray_ready,
    output logic               gray_req,
    output logic [AW-1:0]      gray_addr,
    input  logic [DW-1:0]      gray_data,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ-1:0]    req_last_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [DW-1:0]      rdata_o,
    output logic [NREQ-1:0]    rvalid_o,
    input  logic [NREQ-1:0]    fin_i,
    output logic               finish
`ifdef GRAY_ARB_STAT_EN
    ,
    output logic [NREQ*16-1:0] stat_o
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [AW-1:0]    addr_hold;

    logic [AW-1:0]    owner_addr;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_burst;
    logic             rel;
    logic [PW-1:0]    owner_inc;
    logic [NREQ-1:0]  hand_mask;
    logic [PW-1:0]    idle_idx;
    logic             idle_found;
    logic [PW-1:0]    hand_idx;
    logic             hand_found;

    assign owner_addr = req_addr_i[owner*AW +: AW];
    assign gray_req   = (state == OWN) && gray_ready && req_i[owner];
    // Address is only driven from the owner while a beat is live; otherwise it parks.
    assign gray_addr  = gray_req ? owner_addr : addr_hold;
    assign cnt_inc    = beat_cnt + CNT_W'(1);
    assign at_burst   = gray_req && (cnt_inc == CNT_W'(BURST));
    // A stalled memory freezes the grant, so release is only evaluated when ready.
    assign rel        = (state == OWN) && gray_ready &&
                        (gray_req ? (req_last_i[owner] || at_burst) : !req_i[owner]);
    assign owner_inc  = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
    // A burst-limit release must hand over to someone else, never back to the owner.
    assign hand_mask  = at_burst ? (NREQ'(1) << owner) : '0;

    // One-hot beat acknowledge to the current owner.
    always_comb begin
        gnt_o        = '0;
        gnt_o[owner] = gray_req;
    end

    rr_pick #(.N(NREQ), .PW(PW)) u_idle_pick (
        .req   (req_i),
        .start (ptr),
        .mask  ('0),
        .idx   (idle_idx),
        .found (idle_found)
    );

    rr_pick #(.N(NREQ), .PW(PW)) u_hand_pick (
        .req   (req_i),
        .start (owner_inc),
        .mask  (hand_mask),
        .idx   (hand_idx),
        .found (hand_found)
    );

    // Arbitration FSM, beat counting, read-data return and finish merge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
            addr_hold <= '0;
            rdata_o   <= '0;
            rvalid_o  <= '0;
            finish    <= 1'b0;
        end else begin
            finish   <= &fin_i;
            rvalid_o <= '0;
            if (state == IDLE) begin
                if (gray_ready && idle_found) begin
                    owner    <= idle_idx;
                    beat_cnt <= '0;
                    state    <= OWN;
                end
            end else begin
                if (gray_req) begin
                    rdata_o   <= gray_data;
                    rvalid_o  <= NREQ'(1) << owner;
                    addr_hold <= owner_addr;
                    beat_cnt  <= cnt_inc;
                end
                if (rel) begin
                    ptr      <= owner_inc;
                    beat_cnt <= '0;
                    if (hand_found) begin
                        owner <= hand_idx;
                    end else begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

`ifdef GRAY_ARB_STAT_EN
    // Per-engine beat counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (!reset) begin
                stat_o[k*16 +: 16] <= '0;
            end else if (gnt_o[k] && (stat_o[k*16 +: 16] != 16'hFFFF)) begin
                stat_o[k*16 +: 16] <= stat_o[k*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_rd_arb.sv
// Self-checking bench for gray_rd_arb: directed scenarios followed by random traffic,
// checked against a behavioural arbiter model and a read-data scoreboard.
module tb_gray_rd_arb;
    import gray_arb_pkg::*;

    localparam int NREQ  = 2;
    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int BURST = 9;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               gray_ready = 1'b0;
    logic               gray_req;
    logic [AW-1:0]      gray_addr;
    logic [DW-1:0]      gray_data;
    logic [NREQ-1:0]    req_i = '0;
    logic [NREQ*AW-1:0] req_addr_i = '0;
    logic [NREQ-1:0]    req_last_i = '0;
    logic [NREQ-1:0]    gnt_o;
    logic [DW-1:0]      rdata_o;
    logic [NREQ-1:0]    rvalid_o;
    logic [NREQ-1:0]    fin_i = '0;
    logic               finish;
`ifdef GRAY_ARB_STAT_EN
    logic [NREQ*16-1:0] stat_o;
`endif

    logic [DW-1:0] mem [IMG_PIX];

    gray_rd_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST(BURST)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .req_i      (req_i),
        .req_addr_i (req_addr_i),
        .req_last_i (req_last_i),
        .gnt_o      (gnt_o),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .fin_i      (fin_i),
        .finish     (finish)
`ifdef GRAY_ARB_STAT_EN
        ,
        .stat_o     (stat_o)
`endif
    );

    always #5 clk = ~clk;

    assign gray_data = mem[gray_addr];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            eng;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    // Reference model state.
    bit            m_idle = 1'b1;
    int            m_owner = 0;
    int            m_ptr = 0;
    int            m_cnt = 0;
    bit            m_fin = 1'b0;
    logic [AW-1:0] m_hold = '0;
    logic [DW-1:0] m_rdata = '0;
    int            m_stat[NREQ];

    // Engine stimulus state: a burst is a 3x3 window (len 1..9) or an endless stream (len 0).
    bit e_act[NREQ];
    int e_base[NREQ];
    int e_beat[NREQ];
    int e_len[NREQ];
    bit e_pause[NREQ];
    bit random_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eng_addr(input int k);
        if (e_len[k] == 0) return (e_base[k] + e_beat[k]) % IMG_PIX;
        return (e_base[k] + (e_beat[k] / 3) * IMG_W + (e_beat[k] % 3)) % IMG_PIX;
    endfunction

    function automatic int first_from(input int start, input int excl);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (start + i) % NREQ;
            if (req_i[k] && k != excl) return k;
        end
        return -1;
    endfunction

    task automatic start_burst(input int k, input int base, input int len);
        e_act[k]  = 1'b1;
        e_base[k] = base;
        e_beat[k] = 0;
        e_len[k]  = len;
    endtask

    // One clock cycle: drive at negedge, compare combinational outputs, advance the model.
    task automatic step(input bit rst_n, input bit rdy, input logic [NREQ-1:0] fin);
        bit            eq;
        logic [NREQ-1:0] egnt;
        logic [AW-1:0] eaddr;
        bit            rel;
        bit            forced;
        int            nxt;
        int            g;
        @(negedge clk);
        reset      = rst_n;
        gray_ready = rdy;
        fin_i      = fin;
        for (int k = 0; k < NREQ; k++) begin
            req_i[k]               = e_act[k] && !e_pause[k];
            req_addr_i[k*AW +: AW] = AW'(eng_addr(k));
            req_last_i[k]          = e_act[k] && (e_len[k] != 0) && (e_beat[k] == e_len[k] - 1);
        end
        #1;
        eq    = !m_idle && rdy && req_i[m_owner];
        egnt  = eq ? (NREQ'(1) << m_owner) : '0;
        eaddr = eq ? req_addr_i[m_owner*AW +: AW] : m_hold;
        check("sb_drain", 64'(sbq.size()), 64'd0);
        check("gray_req", 64'(gray_req), 64'(eq));
        check("gnt", 64'(gnt_o), 64'(egnt));
        check("gray_addr", 64'(gray_addr), 64'(eaddr));
        check("finish", 64'(finish), 64'(m_fin));
        check("rdata_hold", 64'(rdata_o), 64'(m_rdata));
        check("rvalid_onehot", 64'($countones(rvalid_o) <= 1), 64'd1);
`ifdef GRAY_ARB_STAT_EN
        for (int k = 0; k < NREQ; k++) check("stat", 64'(stat_o[k*16 +: 16]), 64'(m_stat[k]));
`endif
        if (eq && rst_n) sbq.push_back('{m_owner, mem[eaddr]});
        g = eq ? m_owner : -1;

        if (!rst_n) begin
            m_idle = 1'b1; m_owner = 0; m_ptr = 0; m_cnt = 0;
            m_fin = 1'b0; m_hold = '0; m_rdata = '0;
            for (int k = 0; k < NREQ; k++) m_stat[k] = 0;
        end else begin
            m_fin = &fin;
            if (m_idle) begin
                if (rdy && req_i != 0) begin
                    m_owner = first_from(m_ptr, -1);
                    m_cnt   = 0;
                    m_idle  = 1'b0;
                end
            end else if (rdy) begin
                rel = 1'b0;
                forced = 1'b0;
                if (eq) begin
                    m_cnt++;
                    m_hold  = eaddr;
                    m_rdata = mem[eaddr];
                    if (m_stat[m_owner] < 16'hFFFF) m_stat[m_owner]++;
                    forced = (m_cnt == BURST);
                    rel    = req_last_i[m_owner] || forced;
                end else begin
                    rel = 1'b1;
                end
                if (rel) begin
                    m_ptr = (m_owner + 1) % NREQ;
                    nxt   = first_from(m_ptr, forced ? m_owner : -1);
                    m_cnt = 0;
                    if (nxt >= 0) m_owner = nxt;
                    else m_idle = 1'b1;
                end
            end
        end

        if (g >= 0) begin
            e_beat[g]++;
            if (e_len[g] != 0 && e_beat[g] == e_len[g]) e_act[g] = 1'b0;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!rst_n) e_act[k] = 1'b0;
            e_pause[k] = 1'b0;
            if (random_mode) begin
                e_pause[k] = ($urandom_range(0, 9) == 0);
                if (!e_act[k] && $urandom_range(0, 3) == 0)
                    start_burst(k, int'($urandom_range(0, IMG_PIX - 1)), int'($urandom_range(1, 9)));
            end
        end
    endtask

    task automatic wait_beats(input int k, input int n, input string name);
        for (int i = 0; i < 60 && e_beat[k] < n; i++) step(1'b1, 1'b1, '0);
        if (e_beat[k] < n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got %0d beats expected %0d", name, e_beat[k], n);
        end
    endtask

    // Scoreboard monitor: every rvalid pulse must match the oldest expected beat.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rvalid_o != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_spurious: got rvalid %0b expected none", rvalid_o);
                end else begin
                    e = sbq.pop_front();
                    check("rvalid", 64'(rvalid_o), 64'(NREQ'(1) << e.eng));
                    check("rdata", 64'(rdata_o), 64'(e.data));
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rfin;
        bit              rrdy;
        for (int i = 0; i < IMG_PIX; i++) mem[i] = DW'($urandom);
        for (int k = 0; k < NREQ; k++) begin
            e_act[k] = 1'b0; e_base[k] = 0; e_beat[k] = 0; e_len[k] = 0; e_pause[k] = 1'b0;
            m_stat[k] = 0;
        end
        repeat (3) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, '0);

        // Single engine, one 3x3 window from address 0.
        start_burst(0, 0, 9);
        repeat (14) step(1'b1, 1'b1, '0);

        // Continuous contention with no last beats: forced rotation every BURST beats.
        start_burst(0, 1000, 0);
        start_burst(1, 2000, 0);
        repeat (60) step(1'b1, 1'b1, '0);
        e_act[0] = 1'b0;
        e_act[1] = 1'b0;
        repeat (3) step(1'b1, 1'b1, '0);

        // Memory stall for three cycles after beat 4.
        start_burst(0, 300, 9);
        wait_beats(0, 4, "stall_reach");
        repeat (3) step(1'b1, 1'b0, '0);
        repeat (10) step(1'b1, 1'b1, '0);

        // Owner abandons its burst after two beats while engine 1 waits.
        start_burst(0, 500, 9);
        wait_beats(0, 1, "drop_first");
        start_burst(1, 700, 9);
        wait_beats(0, 2, "drop_reach");
        e_act[0] = 1'b0;
        repeat (15) step(1'b1, 1'b1, '0);

        // Reset during beat 5 aborts the burst.
        start_burst(0, 900, 9);
        wait_beats(0, 4, "reset_reach");
        step(1'b0, 1'b1, '0);
        repeat (2) step(1'b1, 1'b1, '0);
        start_burst(0, 4000, 3);
        start_burst(1, 5000, 3);
        repeat (10) step(1'b1, 1'b1, '0);

        // Finish merge.
        repeat (3) step(1'b1, 1'b1, 2'b01);
        repeat (3) step(1'b1, 1'b1, 2'b11);
        repeat (2) step(1'b1, 1'b1, 2'b10);

        // Random traffic, random stalls and random finish flags.
        random_mode = 1'b1;
        rfin = '0;
        for (int i = 0; i < 1500; i++) begin
            rrdy = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 15) == 0) rfin = NREQ'($urandom);
            step(1'b1, rrdy, rfin);
        end
        random_mode = 1'b0;
        for (int k = 0; k < NREQ; k++) e_act[k] = 1'b0;
        repeat (5) step(1'b1, 1'b1, '0);
        check("sb_empty_end", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
